// File: rtl/bin2bcd_seq_pkg.sv
// Shared BCD definitions: digit width and converter FSM encoding.
// Reused by the display-side blocks downstream of the converter.
package bin2bcd_seq_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // True when DIGITS decimal digits can hold every W-bit unsigned value.
    function automatic bit bcd_fits(int w, int digits);
        longint unsigned p;
        longint unsigned maxv;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        maxv = (longint'(1) << w) - 1;
        return p > maxv;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD digit of 5 or more.
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// Holds the last result on bcd until the next conversion completes.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [W-1:0]                  bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int SW = BW + W;
    localparam int CW = $clog2(W + 1);

    if (W < 1 || !bcd_fits(W, DIGITS)) begin : g_param_chk
        $error("bin2bcd_seq: DIGITS too small for W");
    end

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [SW-1:0] sh;
    logic [SW-1:0] sh_adj;
    logic [SW-1:0] sh_next;
    logic          accept;
    logic          last;

    assign busy   = (state == SHIFT);
    assign accept = (state == IDLE) && start;
    assign last   = (count == CW'(W - 1));

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (sh[W + BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .dout (sh_adj[W + BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    assign sh_adj[W-1:0] = sh[W-1:0];
    assign sh_next       = sh_adj << 1;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = SHIFT;
            SHIFT: if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh    <= '0;
            count <= '0;
            bcd   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                sh    <= {{BW{1'b0}}, bin};
                count <= '0;
            end else if (state == SHIFT) begin
                sh    <= sh_next;
                count <= count + CW'(1);
                // Final shift: publish the digit field directly from sh_next.
                if (last) begin
                    bcd  <= sh_next[SW-1:W];
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against a decimal-arithmetic model.
module tb_bin2bcd_seq;

    localparam int W      = 8;
    localparam int DIGITS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last_done_cyc = -1;

    bin2bcd_seq #(.W(W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ref_bcd(int v);
        logic [11:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a conversion and wait (bounded) for done; checks latency and result.
    task automatic convert(input logic [7:0] v, input bit hold,
                           input bit chg, input logic [7:0] mid,
                           input bit chk_space);
        int n;
        int ndone;
        bin   = v;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        if (chg) bin = mid;
        chk("busy_after_accept", busy, 1);
        n = 0;
        ndone = 0;
        while (!done && n < W + 4) begin
            step();
            n++;
        end
        start = 1'b0;
        if (done) ndone++;
        chk("latency", n, W);
        chk("done_seen", ndone, 1);
        chk("bcd_result", bcd, ref_bcd(v));
        chk("busy_at_done", busy, 0);
        if (chk_space) chk("spacing", cyc - last_done_cyc, W + 1);
        last_done_cyc = cyc;
    endtask

    initial begin
        int nd;
        logic [7:0] v;
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 0);
        rst = 1'b0;
        step();

        convert(8'd0, 0, 0, 8'd0, 0);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_busy", busy, 0);

        convert(8'd255, 0, 0, 8'd0, 0);
        step();
        chk("t2_done_pulse", done, 0);
        chk("t2_hold", bcd, 12'h255);

        // start held high throughout, including on the done edge
        convert(8'd99, 1, 0, 8'd0, 0);
        step();
        chk("t3_no_accept_at_done", busy, 0);
        nd = 0;
        for (int i = 0; i < W + 2; i++) begin
            step();
            if (done) nd++;
        end
        chk("t3_no_extra_done", nd, 0);
        chk("t3_bcd", bcd, 12'h099);

        // reset on the 4th shift aborts
        bin   = 8'd200;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_bcd", bcd, 0);
        nd = 0;
        for (int i = 0; i < W + 2; i++) begin
            step();
            if (done) nd++;
        end
        chk("t4_no_done", nd, 0);

        // rst wins over start on the same edge
        rst   = 1'b1;
        start = 1'b1;
        bin   = 8'd50;
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", busy, 0);
        step();
        chk("rst_prio_busy2", busy, 0);

        convert(8'd128, 0, 1, 8'd7, 0);
        step();
        chk("t5_hold", bcd, 12'h128);

        // back-to-back sweep
        last_done_cyc = -1;
        for (int i = 0; i < 256; i++) begin
            convert(8'(i), 0, 0, 8'd0, i != 0);
        end

        // random values with random idle gaps
        for (int i = 0; i < 40; i++) begin
            v = 8'($urandom);
            convert(v, 0, 1, 8'($urandom), 0);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                step();
                chk("rand_hold", bcd, ref_bcd(int'(v)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
